// File: rtl/instr_encoder.sv
// Packs one decoded control bundle per handshake into a 32-bit MIPS word and
// writes it to instruction memory at an auto-incrementing address until HLT.
module instr_encoder #(
    parameter int unsigned          ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              r,
    input  logic              lw,
    input  logic              sw,
    input  logic              branch,
    input  logic              jmp,
    input  logic              hlt,
    input  logic [2:0]        func,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] count
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                hlt_pending_q, hlt_pending_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   count_q, count_d;

    logic [5:0]          class_vec;
    logic                well_formed;
    logic                handshake;
    logic                acked;
    logic [5:0]          r_funct;
    logic [31:0]         enc_word;

    assign class_vec   = {r, lw, sw, branch, jmp, hlt};
    assign well_formed = $onehot(class_vec);

    // A pending write may be replaced in the same cycle it is acked.
    assign in_ready  = (state_q == S_RUN) && !hlt_pending_q && (!mem_we_q || mem_ack);
    assign handshake = in_valid && in_ready;
    assign acked     = mem_we_q && mem_ack;

    always_comb begin
        r_funct = 6'b100001;
        case (func)
            3'b000:  r_funct = 6'b100000;
            3'b001:  r_funct = 6'b100010;
            3'b010:  r_funct = 6'b100100;
            3'b011:  r_funct = 6'b100101;
            default: r_funct = 6'b100001;
        endcase
    end

    always_comb begin
        enc_word = 32'h0;
        if (r)
            enc_word = {6'b000000, rs, rt, rd, 5'b00000, r_funct};
        else if (lw)
            enc_word = {6'b100011, rs, rt, imm};
        else if (sw)
            enc_word = {6'b101011, rs, rt, imm};
        else if (branch)
            enc_word = {6'b000100, rs, rt, imm};
        else if (jmp)
            enc_word = {6'b000010, target};
        else if (hlt)
            enc_word = {6'b111111, 26'h0};
    end

    always_comb begin
        state_d       = state_q;
        hlt_pending_d = hlt_pending_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        done_d        = done_q;
        err_d         = err_q;
        count_d       = count_q;

        if (acked) begin
            mem_we_d   = 1'b0;
            mem_addr_d = mem_addr_q + 1'b1;
            count_d    = count_q + 1'b1;
            if (hlt_pending_q) begin
                hlt_pending_d = 1'b0;
                state_d       = S_DONE;
                done_d        = 1'b1;
            end
        end

        // Malformed bundles are consumed but never reach memory.
        if (handshake) begin
            if (well_formed) begin
                mem_we_d    = 1'b1;
                mem_wdata_d = enc_word;
                if (hlt)
                    hlt_pending_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        if ((state_q == S_DONE) && restart) begin
            state_d    = S_RUN;
            mem_addr_d = BASE_ADDR;
            count_d    = '0;
            err_d      = 1'b0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_RUN;
            hlt_pending_q <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= BASE_ADDR;
            mem_wdata_q   <= 32'h0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            hlt_pending_q <= hlt_pending_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            done_q        <= done_d;
            err_q         <= err_d;
            count_q       <= count_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed encodings, backpressure,
// malformed bundles, HLT/restart, and address wrap with a 2-bit address.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset, reset2;
    logic        in_valid, in_valid2;
    logic        in_ready, in_ready2;
    logic        r, lw, sw, branch, jmp, hlt;
    logic [2:0]  func;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic        restart;
    logic        mem_we, mem_we2;
    logic [7:0]  mem_addr;
    logic [1:0]  mem_addr2;
    logic [31:0] mem_wdata, mem_wdata2;
    logic        mem_ack, mem_ack2;
    logic        done, done2;
    logic        err, err2;
    logic [7:0]  count;
    logic [1:0]  count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'd0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .r(r), .lw(lw), .sw(sw), .branch(branch), .jmp(jmp), .hlt(hlt),
        .func(func), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
        .restart(restart), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .done(done), .err(err),
        .count(count)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd0)) dut2 (
        .clk(clk), .reset(reset2), .in_valid(in_valid2), .in_ready(in_ready2),
        .r(r), .lw(lw), .sw(sw), .branch(branch), .jmp(jmp), .hlt(hlt),
        .func(func), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
        .restart(restart), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_ack(mem_ack2), .done(done2), .err(err2),
        .count(count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bundle();
        {r, lw, sw, branch, jmp, hlt} = 6'b0;
        func = 3'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; imm = 16'h0; target = 26'h0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        in_valid = 1'b0; in_valid2 = 1'b0;
        mem_ack = 1'b0; mem_ack2 = 1'b0;
        restart = 1'b0;
        clear_bundle();
        tick();
        $display("reset state");
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_addr", {24'b0, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_done_err", {30'b0, done, err}, 32'd0);
        chk("rst_count", {24'b0, count}, 32'd0);
        reset = 1'b0; reset2 = 1'b0;

        // ADD r3,r1,r2 with ack tied high
        r = 1'b1; func = 3'b000; rs = 5'd1; rt = 5'd2; rd = 5'd3;
        mem_ack = 1'b1; in_valid = 1'b1;
        #1 chk("add_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        $display("ADD r3,r1,r2 -> %h @%0d", mem_wdata, mem_addr);
        chk("add_we", {31'b0, mem_we}, 32'd1);
        chk("add_addr", {24'b0, mem_addr}, 32'd0);
        chk("add_wdata", mem_wdata, 32'h00221820);
        tick();
        chk("add_count", {24'b0, count}, 32'd1);
        chk("add_we_drop", {31'b0, mem_we}, 32'd0);

        // LW then BEQ, continuous ack
        pulse_reset();
        clear_bundle();
        lw = 1'b1; rs = 5'd29; rt = 5'd8; imm = 16'h0004; in_valid = 1'b1;
        tick();
        $display("LW -> %h @%0d", mem_wdata, mem_addr);
        chk("lw_wdata", mem_wdata, 32'h8FA80004);
        chk("lw_addr", {24'b0, mem_addr}, 32'd0);
        clear_bundle();
        branch = 1'b1; rs = 5'd1; rt = 5'd2; imm = 16'hFFFE;
        #1 chk("beq_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        $display("BEQ -> %h @%0d", mem_wdata, mem_addr);
        chk("beq_we", {31'b0, mem_we}, 32'd1);
        chk("beq_wdata", mem_wdata, 32'h1022FFFE);
        chk("beq_addr", {24'b0, mem_addr}, 32'd1);
        tick();
        chk("beq_count", {24'b0, count}, 32'd2);

        // SW under backpressure
        pulse_reset();
        clear_bundle();
        mem_ack = 1'b0;
        sw = 1'b1; rs = 5'd2; rt = 5'd5; imm = 16'h0010; in_valid = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            $display("SW stall %0d -> we=%0b %h @%0d", i, mem_we, mem_wdata, mem_addr);
            chk("sw_hold_we", {31'b0, mem_we}, 32'd1);
            chk("sw_hold_wdata", mem_wdata, 32'hAC450010);
            chk("sw_hold_addr", {24'b0, mem_addr}, 32'd0);
            chk("sw_in_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        mem_ack = 1'b1;
        tick();
        chk("sw_count", {24'b0, count}, 32'd1);
        chk("sw_we_drop", {31'b0, mem_we}, 32'd0);

        // Malformed (r+lw), then OR at the unchanged address
        clear_bundle();
        r = 1'b1; lw = 1'b1; in_valid = 1'b1;
        tick();
        $display("malformed -> we=%0b err=%0b count=%0d", mem_we, err, count);
        chk("bad_we", {31'b0, mem_we}, 32'd0);
        chk("bad_err", {31'b0, err}, 32'd1);
        chk("bad_count", {24'b0, count}, 32'd1);
        clear_bundle();
        r = 1'b1; func = 3'b011; rs = 5'd4; rt = 5'd5; rd = 5'd6;
        tick();
        in_valid = 1'b0;
        $display("OR -> %h @%0d", mem_wdata, mem_addr);
        chk("or_wdata", mem_wdata, 32'h00853025);
        chk("or_addr", {24'b0, mem_addr}, 32'd1);
        tick();
        chk("or_count", {24'b0, count}, 32'd2);
        chk("or_err_sticky", {31'b0, err}, 32'd1);

        // JMP, HLT, DONE, restart
        pulse_reset();
        clear_bundle();
        jmp = 1'b1; target = 26'h40; in_valid = 1'b1;
        tick();
        $display("JMP -> %h @%0d", mem_wdata, mem_addr);
        chk("jmp_wdata", mem_wdata, 32'h08000040);
        clear_bundle();
        hlt = 1'b1;
        tick();
        $display("HLT -> %h @%0d", mem_wdata, mem_addr);
        chk("hlt_wdata", mem_wdata, 32'hFC000000);
        chk("hlt_addr", {24'b0, mem_addr}, 32'd1);
        clear_bundle();
        jmp = 1'b1; target = 26'h40;
        #1 chk("hlt_pend_ready", {31'b0, in_ready}, 32'd0);
        tick();
        chk("hlt_done", {31'b0, done}, 32'd1);
        chk("hlt_count", {24'b0, count}, 32'd2);
        tick();
        $display("DONE -> done=%0b ready=%0b we=%0b count=%0d", done, in_ready, mem_we, count);
        chk("done_ready", {31'b0, in_ready}, 32'd0);
        chk("done_ignored", {31'b0, mem_we}, 32'd0);
        chk("done_count", {24'b0, count}, 32'd2);
        in_valid = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        $display("restart -> addr=%0d count=%0d ready=%0b", mem_addr, count, in_ready);
        chk("rs_addr", {24'b0, mem_addr}, 32'd0);
        chk("rs_count", {24'b0, count}, 32'd0);
        chk("rs_done", {31'b0, done}, 32'd0);
        chk("rs_ready", {31'b0, in_ready}, 32'd1);

        // Wrap with ADDR_W=2, then reset mid-write
        clear_bundle();
        r = 1'b1; rs = 5'd1; rt = 5'd2; rd = 5'd3;
        mem_ack2 = 1'b1; in_valid2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            $display("wrap ADD %0d -> %h @%0d", i, mem_wdata2, mem_addr2);
            chk("wrap_addr", {30'b0, mem_addr2}, i % 4);
        end
        in_valid2 = 1'b0;
        mem_ack2 = 1'b0;
        chk("wrap_we", {31'b0, mem_we2}, 32'd1);
        chk("wrap_count", {30'b0, count2}, 32'd0);
        tick();
        reset2 = 1'b1;
        #1;
        $display("reset mid-write -> we=%0b addr=%0d", mem_we2, mem_addr2);
        chk("midrst_we", {31'b0, mem_we2}, 32'd0);
        chk("midrst_addr", {30'b0, mem_addr2}, 32'd0);
        reset2 = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
